// File: rtl/memory_bank_arbiter_if.sv
// Requester handshake bundle and bank-side port of the memory bank arbiter.
// The arbiter connects through the slave modport; the requester/bank side uses master.
interface memory_bank_arbiter_if #(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned WORD_W = 16
);
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        we;
  logic [NREQ*ADDR_W-1:0] addr;
  logic [NREQ*WORD_W-1:0] wdata;
  logic [NREQ-1:0]        ack;
  logic                   err;
  logic [WORD_W-1:0]      rdata;
  logic                   busy;
  logic                   mem_wr_en;
  logic [ADDR_W-1:0]      mem_index;
  logic [WORD_W-1:0]      mem_data_in;
  logic [WORD_W-1:0]      mem_data_out;

  modport master (
    output req, we, addr, wdata, mem_data_out,
    input  ack, err, rdata, busy, mem_wr_en, mem_index, mem_data_in
  );

  modport slave (
    input  req, we, addr, wdata, mem_data_out,
    output ack, err, rdata, busy, mem_wr_en, mem_index, mem_data_in
  );
endinterface

// File: rtl/memory_bank_arbiter.sv
// Round-robin arbiter sharing a byte-addressed memory bank between NREQ requesters,
// one 16-bit word access per grant with a four-phase req/ack handshake.
module memory_bank_arbiter #(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned WORD_W = 16
) (
  input logic                  clk,
  input logic                  nrst,
  memory_bank_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e            r_state;
  logic [1:0]        r_gnt;
  logic [1:0]        r_last;
  logic              r_we;
  logic [ADDR_W-1:0] r_mem_index;
  logic [WORD_W-1:0] r_mem_data_in;
  logic [WORD_W-1:0] r_rdata;
  logic [NREQ-1:0]   r_ack;
  logic              r_err;
  logic              r_busy;

  logic              w_any;
  logic [1:0]        w_gnt;
  logic [1:0]        w_idx;

  // First pending requester searching last+1, last+2, ... modulo NREQ.
  always_comb begin
    w_any = 1'b0;
    w_gnt = r_last;
    w_idx = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      w_idx = 2'((32'(r_last) + i) % NREQ);
      if (!w_any && bus.req[w_idx]) begin
        w_any = 1'b1;
        w_gnt = w_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state       <= StIdle;
      r_gnt         <= '0;
      r_last        <= 2'(NREQ - 1);
      r_we          <= 1'b0;
      r_mem_index   <= '0;
      r_mem_data_in <= '0;
      r_rdata       <= '0;
      r_ack         <= '0;
      r_err         <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_any) begin
            r_gnt         <= w_gnt;
            r_last        <= w_gnt;
            r_we          <= bus.we[w_gnt];
            r_mem_index   <= bus.addr[32'(w_gnt) * ADDR_W +: ADDR_W];
            r_mem_data_in <= bus.wdata[32'(w_gnt) * WORD_W +: WORD_W];
            r_busy        <= 1'b1;
            r_state       <= StAccess;
          end
        end
        StAccess: begin
          // Odd index would straddle two words (or run off the bank end at the top).
          if (r_mem_index[0]) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
          end else if (!r_we) begin
            r_rdata <= bus.mem_data_out;
          end
          r_ack   <= NREQ'(1) << r_gnt;
          r_state <= StResp;
        end
        StResp: begin
          if (!bus.req[r_gnt]) begin
            r_ack   <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Write strobe comes straight from flops, so async reset kills it immediately.
  assign bus.mem_wr_en   = (r_state == StAccess) && r_we && !r_mem_index[0];
  assign bus.mem_index   = r_mem_index;
  assign bus.mem_data_in = r_mem_data_in;
  assign bus.ack         = r_ack;
  assign bus.err         = r_err;
  assign bus.rdata       = r_rdata;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_memory_bank_arbiter.sv
// Self-checking bench for memory_bank_arbiter: directed vector table, multi-cycle corner
// sequences and randomized batches scored against a behavioural model of bank and arbiter.
module tb_memory_bank_arbiter;
  localparam int unsigned NREQ   = 3;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned WORD_W = 16;

  logic clk = 1'b0;
  logic nrst = 1'b0;

  memory_bank_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .WORD_W(WORD_W)) bif ();

  memory_bank_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bif.slave)
  );

  always #5 clk = ~clk;

  // Bank: 64 byte cells, combinational word read at index/index+1.
  logic [7:0] bank [64] = '{default: 8'h00};
  int wr_cnt = 0;
  assign bif.mem_data_out = {bank[bif.mem_index + 6'd1], bank[bif.mem_index]};
  always @(posedge clk) begin
    if (bif.mem_wr_en) begin
      bank[bif.mem_index]        <= bif.mem_data_in[7:0];
      bank[bif.mem_index + 6'd1] <= bif.mem_data_in[15:8];
      wr_cnt                     <= wr_cnt + 1;
    end
  end

  // Reference model state.
  logic [7:0]  mdl [64] = '{default: 8'h00};
  logic [15:0] m_rdata = 16'h0;
  int          last_m = 2;
  logic        t_w [3];
  logic [5:0]  t_a [3];
  logic [15:0] t_d [3];

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    int          k;
    logic        w;
    logic [5:0]  a;
    logic [15:0] d;
    logic        e_err;
    logic [15:0] e_rd;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int exp_winner(input logic [2:0] pend);
    for (int i = 1; i <= 3; i++) begin
      if (pend[(last_m + i) % 3]) return (last_m + i) % 3;
    end
    return -1;
  endfunction

  function automatic logic [15:0] exp_rd(input logic w, input logic [5:0] a);
    if (a[0]) return 16'h0;
    if (w) return m_rdata;
    return {mdl[6'(a + 6'd1)], mdl[a]};
  endfunction

  task automatic mdl_commit(input int k, input logic w, input logic [5:0] a,
                            input logic [15:0] d, input logic [15:0] rd);
    if (w && !a[0]) begin
      mdl[a]              = d[7:0];
      mdl[6'(a + 6'd1)]   = d[15:8];
    end
    m_rdata = rd;
    last_m  = k;
  endtask

  task automatic set_req(input int k, input logic w, input logic [5:0] a, input logic [15:0] d);
    bif.we[k]              = w;
    bif.addr[k*6 +: 6]     = a;
    bif.wdata[k*16 +: 16]  = d;
    t_w[k] = w;
    t_a[k] = a;
    t_d[k] = d;
  endtask

  task automatic do_reset();
    nrst    = 1'b0;
    bif.req = '0;
    @(negedge clk);
    nrst    = 1'b1;
    last_m  = 2;
    m_rdata = 16'h0;
  endtask

  // One lone-requester transaction with exact latency checks; called at a negedge in idle.
  task automatic single(input int k, input logic w, input logic [5:0] a, input logic [15:0] d,
                        input int hold, input logic e_err, input logic [15:0] e_rd,
                        input string nm);
    int   w0;
    logic e_wr;
    e_wr = w & ~a[0];
    set_req(k, w, a, d);
    bif.req    = '0;
    bif.req[k] = 1'b1;
    w0 = wr_cnt;
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_acc_busy"}, 32'(bif.busy), 32'd1);
    chk({nm, "_acc_ack"}, 32'(bif.ack), 32'd0);
    chk({nm, "_acc_wren"}, 32'(bif.mem_wr_en), 32'(e_wr));
    if (e_wr) begin
      chk({nm, "_acc_index"}, 32'(bif.mem_index), 32'(a));
      chk({nm, "_acc_data"}, 32'(bif.mem_data_in), 32'(d));
    end
    @(negedge clk);
    chk({nm, "_ack"}, 32'(bif.ack), 32'(1 << k));
    chk({nm, "_err"}, 32'(bif.err), 32'(e_err));
    chk({nm, "_rdata"}, 32'(bif.rdata), 32'(e_rd));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({nm, "_hold_ack"}, 32'(bif.ack), 32'(1 << k));
    end
    bif.req = '0;
    @(negedge clk);
    chk({nm, "_end_ack"}, 32'(bif.ack), 32'd0);
    chk({nm, "_end_busy"}, 32'(bif.busy), 32'd0);
    chk({nm, "_end_err"}, 32'(bif.err), 32'd0);
    chk({nm, "_writes"}, 32'(wr_cnt - w0), 32'(e_wr));
    mdl_commit(k, w, a, d, e_rd);
  endtask

  task automatic single_m(input int k, input logic w, input logic [5:0] a, input logic [15:0] d,
                          input int hold, input string nm);
    single(k, w, a, d, hold, a[0], exp_rd(w, a), nm);
  endtask

  // Several requesters raise together; each drops after its ack and stays down.
  task automatic run_batch(input logic [2:0] mask);
    logic [2:0]  pend;
    logic [15:0] e;
    int          w;
    int          waited;
    bit          got;
    pend    = mask;
    bif.req = mask;
    while (pend != 0) begin
      w      = exp_winner(pend);
      got    = 1'b0;
      waited = 0;
      while (!got && waited < 8) begin
        @(negedge clk);
        waited++;
        if (bif.ack != 0) got = 1'b1;
      end
      if (!got) begin
        n_chk++;
        n_err++;
        $display("FAIL batch_timeout: got no ack expected ack for requester %0d", w);
        do_reset();
        return;
      end
      e = exp_rd(t_w[w], t_a[w]);
      chk("batch_grant", 32'(bif.ack), 32'(1 << w));
      chk("batch_err", 32'(bif.err), 32'(t_a[w][0]));
      chk("batch_rdata", 32'(bif.rdata), 32'(e));
      mdl_commit(w, t_w[w], t_a[w], t_d[w], e);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      bif.req[w] = 1'b0;
      pend[w]    = 1'b0;
      @(negedge clk);
      chk("batch_ack_fall", 32'(bif.ack), 32'd0);
    end
    chk("batch_idle", 32'(bif.busy), 32'd0);
  endtask

  initial begin
    int w;
    int waited;
    int w0;
    bit got;

    bif.req   = '0;
    bif.we    = '0;
    bif.addr  = '0;
    bif.wdata = '0;

    tbl[0]  = '{1, 1'b1, 6'h04, 16'hBEEF, 1'b0, 16'h0000};
    tbl[1]  = '{1, 1'b0, 6'h04, 16'h0000, 1'b0, 16'hBEEF};
    tbl[2]  = '{0, 1'b1, 6'h05, 16'h1111, 1'b1, 16'h0000};
    tbl[3]  = '{2, 1'b1, 6'h3F, 16'h2222, 1'b1, 16'h0000};
    tbl[4]  = '{0, 1'b0, 6'h04, 16'h0000, 1'b0, 16'hBEEF};
    tbl[5]  = '{2, 1'b1, 6'h3E, 16'h1234, 1'b0, 16'hBEEF};
    tbl[6]  = '{0, 1'b0, 6'h3E, 16'h0000, 1'b0, 16'h1234};
    tbl[7]  = '{1, 1'b0, 6'h07, 16'h0000, 1'b1, 16'h0000};
    tbl[8]  = '{0, 1'b1, 6'h08, 16'h5A5A, 1'b0, 16'h0000};
    tbl[9]  = '{2, 1'b0, 6'h08, 16'h0000, 1'b0, 16'h5A5A};
    tbl[10] = '{1, 1'b0, 6'h00, 16'h0000, 1'b0, 16'h0000};

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(bif.ack), 32'd0);
    chk("rst_err", 32'(bif.err), 32'd0);
    chk("rst_rdata", 32'(bif.rdata), 32'd0);
    chk("rst_busy", 32'(bif.busy), 32'd0);
    chk("rst_wren", 32'(bif.mem_wr_en), 32'd0);
    chk("rst_index", 32'(bif.mem_index), 32'd0);
    chk("rst_data_in", 32'(bif.mem_data_in), 32'd0);
    nrst = 1'b1;
    @(negedge clk);

    // Directed vectors: write/read, odd-index rejects, readback.
    for (int i = 0; i < 11; i++) begin
      single(tbl[i].k, tbl[i].w, tbl[i].a, tbl[i].d, 0, tbl[i].e_err, tbl[i].e_rd,
             $sformatf("vec%0d", i));
    end

    // Fairness: all three held, each re-raises right after its ack falls.
    do_reset();
    set_req(0, 1'b0, 6'h04, 16'h0);
    set_req(1, 1'b0, 6'h3E, 16'h0);
    set_req(2, 1'b0, 6'h08, 16'h0);
    bif.req = 3'b111;
    for (int g = 0; g < 6; g++) begin
      w      = exp_winner(3'b111);
      got    = 1'b0;
      waited = 0;
      while (!got && waited < 10) begin
        @(negedge clk);
        waited++;
        if (bif.ack != 0) got = 1'b1;
      end
      if (!got) begin
        n_chk++;
        n_err++;
        $display("FAIL fair_timeout: got no ack expected ack for requester %0d", w);
        break;
      end
      chk("fair_grant", 32'(bif.ack), 32'(1 << w));
      chk("fair_rdata", 32'(bif.rdata), 32'(exp_rd(1'b0, t_a[w])));
      if (g > 0) begin
        n_chk++;
        if (waited + 1 < 3) begin
          n_err++;
          $display("FAIL fair_gap: got %0d cycles expected at least 3", waited + 1);
        end
      end
      mdl_commit(w, 1'b0, t_a[w], 16'h0, exp_rd(1'b0, t_a[w]));
      bif.req[w] = 1'b0;
      @(negedge clk);
      chk("fair_ack_fall", 32'(bif.ack), 32'd0);
      if (g < 5) bif.req[w] = 1'b1;
    end
    bif.req = '0;
    @(negedge clk);
    chk("fair_idle", 32'(bif.busy), 32'd0);

    // Reset during the ACCESS cycle of a write to 0x08.
    set_req(0, 1'b1, 6'h08, 16'hDEAD);
    bif.req = 3'b001;
    w0 = wr_cnt;
    @(posedge clk);
    @(negedge clk);
    chk("rstacc_wren", 32'(bif.mem_wr_en), 32'd1);
    nrst = 1'b0;
    #1;
    chk("rstacc_ack", 32'(bif.ack), 32'd0);
    chk("rstacc_busy", 32'(bif.busy), 32'd0);
    chk("rstacc_wren0", 32'(bif.mem_wr_en), 32'd0);
    chk("rstacc_index", 32'(bif.mem_index), 32'd0);
    chk("rstacc_data_in", 32'(bif.mem_data_in), 32'd0);
    chk("rstacc_rdata", 32'(bif.rdata), 32'd0);
    bif.req = '0;
    @(posedge clk);
    @(negedge clk);
    chk("rstacc_nowrite", 32'(wr_cnt - w0), 32'd0);
    nrst    = 1'b1;
    last_m  = 2;
    m_rdata = 16'h0;
    set_req(1, 1'b0, 6'h04, 16'h0);
    set_req(2, 1'b0, 6'h3E, 16'h0);
    run_batch(3'b110);
    single_m(0, 1'b0, 6'h08, 16'h0, 0, "rstacc_readback");

    // Hold: ack stays high for five cycles while req is held.
    single_m(1, 1'b0, 6'h3E, 16'h0, 4, "hold");

    // Abort: req dropped during ACCESS still completes the write.
    set_req(2, 1'b1, 6'h20, 16'hC0DE);
    bif.req = 3'b100;
    w0 = wr_cnt;
    @(posedge clk);
    @(negedge clk);
    chk("abort_wren", 32'(bif.mem_wr_en), 32'd1);
    bif.req = '0;
    @(negedge clk);
    chk("abort_ack", 32'(bif.ack), 32'b100);
    chk("abort_busy", 32'(bif.busy), 32'd1);
    @(negedge clk);
    chk("abort_ack_fall", 32'(bif.ack), 32'd0);
    chk("abort_busy_fall", 32'(bif.busy), 32'd0);
    chk("abort_writes", 32'(wr_cnt - w0), 32'd1);
    mdl_commit(2, 1'b1, 6'h20, 16'hC0DE, m_rdata);
    single_m(0, 1'b0, 6'h20, 16'h0, 0, "abort_readback");

    // Randomized batches of contending requesters.
    for (int b = 0; b < 40; b++) begin
      logic [2:0] m;
      m = 3'($urandom_range(1, 7));
      for (int k = 0; k < 3; k++) begin
        set_req(k, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 17)), 16'($urandom));
      end
      run_batch(m);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
